// File: rtl/io_responder.sv
// io_responder: syscall responder that turns controller runio requests into stream reads/writes or a halt.
// Latency: READ/WRITE finish 2 cycles after runio if the partner is ready; unknown (and CYCLES) 1 cycle; HALT never.
// Backpressure: valid/ready on both streams; waits in READ_WAIT/WRITE_WAIT indefinitely with iobusy held high.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   runio             request from controller, held until iobusy is seen low
//   acc_in, dr_in     syscall number and argument, sampled when the request starts
//   iobusy            combinational busy back to the controller
//   io_result         registered result word for the ACC I/O mux
//   in_valid/in_ready/in_data     input word stream (READ)
//   out_valid/out_ready/out_data  output word stream (WRITE)
//   halted            sticky halt flag
//   bad_call          one-cycle pulse on an unknown syscall number
//
// Optional feature: define IO_RESPONDER_CYCLES_EN to add a free-running cycle
// counter and syscall 3 (CYCLES), which returns the counter value sampled at
// request start. Without it, code 3 is an unknown call.

module io_responder #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             runio,
   input  logic [WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0] dr_in,
   output logic             iobusy,
   output logic [WIDTH-1:0] io_result,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             halted,
   output logic             bad_call
);

   localparam logic [WIDTH-1:0] CALL_HALT   = WIDTH'(0);
   localparam logic [WIDTH-1:0] CALL_READ   = WIDTH'(1);
   localparam logic [WIDTH-1:0] CALL_WRITE  = WIDTH'(2);
`ifdef IO_RESPONDER_CYCLES_EN
   localparam logic [WIDTH-1:0] CALL_CYCLES = WIDTH'(3);
`endif

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_READ_WAIT  = 3'd1,
      S_WRITE_WAIT = 3'd2,
      S_DONE       = 3'd3,
      S_HALT       = 3'd4
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] io_result_q;
   logic [WIDTH-1:0] out_data_q;
   logic             out_valid_q;
   logic             in_ready_q;
   logic             halted_q;
   logic             bad_call_q;

`ifdef IO_RESPONDER_CYCLES_EN
   // Free-running counter; wraps naturally at 2^WIDTH.
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   assign cnt_d = cnt_q + WIDTH'(1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   // Busy is combinational so the controller sees it in the very first cycle
   // runio is high. HALT keeps it high regardless of runio.
   assign iobusy = (runio && (state_q != S_DONE)) || (state_q == S_HALT);

   assign io_result = io_result_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign in_ready  = in_ready_q;
   assign halted    = halted_q;
   assign bad_call  = bad_call_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         io_result_q <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         halted_q    <= 1'b0;
         bad_call_q  <= 1'b0;
      end else begin
         // bad_call is a single-cycle pulse; only the IDLE decode re-arms it.
         bad_call_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (runio) begin
                  if (acc_in == CALL_HALT) begin
                     state_q  <= S_HALT;
                     halted_q <= 1'b1;
                  end else if (acc_in == CALL_READ) begin
                     state_q    <= S_READ_WAIT;
                     in_ready_q <= 1'b1;
                  end else if (acc_in == CALL_WRITE) begin
                     // Argument is captured here and held stable for the whole wait.
                     state_q     <= S_WRITE_WAIT;
                     out_valid_q <= 1'b1;
                     out_data_q  <= dr_in;
`ifdef IO_RESPONDER_CYCLES_EN
                  end else if (acc_in == CALL_CYCLES) begin
                     state_q     <= S_DONE;
                     io_result_q <= cnt_q;
`endif
                  end else begin
                     state_q    <= S_DONE;
                     bad_call_q <= 1'b1;
                  end
               end
            end

            S_READ_WAIT: begin
               if (in_valid && in_ready_q) begin
                  io_result_q <= in_data;
                  in_ready_q  <= 1'b0;
                  state_q     <= S_DONE;
               end
            end

            S_WRITE_WAIT: begin
               if (out_valid_q && out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_DONE;
               end
            end

            S_DONE: begin
               // Stay here until the controller drops runio, so one request
               // can never be taken twice.
               if (!runio) begin
                  state_q <= S_IDLE;
               end
            end

            S_HALT: begin
               state_q <= S_HALT;
            end

            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
